reg_manager: RTL and testbench
==============================

// Module: reg_manager
// PURPOSE
// - Issue side of the execute-unit interface: accepts decoded instructions, reads rs1/rs2 from the
//   integer register file, drives the ALU's unit/sub_unit/sel/operand ports, samples result/branch.
// - Writes results back to rd, and raises a PC redirect on taken branches. Sits between decoder and ALU.
// PARAMETERS
// - XLEN        32   datapath width (equals cpu_pkg::xlen)
// - OK_TIMEOUT  8    EXEC cycles without alu_ok_i before err_o asserts
// PORTS
// - clk             in   1     clock, all state on rising edge
// - rst             in   1     asynchronous, active-high reset
// - dec_valid_i     in   1     decoder instruction valid
// - dec_ready_o     out  1     block can accept instruction this cycle
// - dec_unit_i      in   2     execute unit select (2'h0 = ALU)
// - dec_sub_unit_i  in   3     ALU sub-unit (0 jump/lui, 1 branch, 2 add/sub, 3 logic/slt, 4 shift)
// - dec_sel_i       in   6     operation select within sub-unit
// - dec_rs1_i       in   5     source register 1 index
// - dec_rs2_i       in   5     source register 2 index
// - dec_rd_i        in   5     destination register index
// - dec_imm_i       in   XLEN  immediate value
// - dec_imm_sel_i   in   1     1: ALU operand B is the immediate
// - alu_unit_o      out  2     registered copy of dec_unit_i
// - alu_sub_unit_o  out  3     registered copy of dec_sub_unit_i
// - alu_sel_o       out  6     registered copy of dec_sel_i
// - alu_rs1_o       out  XLEN  rs1 operand value
// - alu_rs2_o       out  XLEN  rs2 operand value
// - alu_rd_o        out  5     destination index
// - alu_immediate_o out  XLEN  immediate
// - alu_imm_o       out  1     immediate select
// - alu_ok_i        in   1     ALU accepts/has completed current op
// - alu_result_i    in   XLEN  ALU result
// - alu_branch_i    in   1     branch condition true
// - redirect_o      out  1     one-cycle pulse: taken branch
// - redirect_pc_o   out  XLEN  branch target (alu_result_i captured)
// - busy_o          out  1     state != IDLE
// - err_o           out  1     sticky: OK_TIMEOUT expired; cleared only by rst
// BEHAVIOUR
// - States: IDLE -> EXEC -> WB -> IDLE. dec_ready_o = (state==IDLE) && !err_o.
// - IDLE: on dec_valid_i && dec_ready_o, latch all dec_* fields and rf[rs1], rf[rs2] into issue regs; go EXEC.
// - EXEC: alu_* outputs driven from issue regs (stable all of EXEC). alu_ok_i=1 -> capture alu_result_i,
//   alu_branch_i; go WB. alu_ok_i=0 -> counter++; counter==OK_TIMEOUT -> set err_o, go IDLE, no write.
// - WB: sub_unit!=1 -> write captured result to rf[rd]; rd==0 write suppressed (x0 reads 0 always).
//   sub_unit==1 -> no rf write; captured branch=1 -> redirect_o=1, redirect_pc_o=captured result.
//   Go IDLE.
// - Latency: accept at cycle N, ALU ops at N+1, rf write/redirect at N+2, ready again N+3.
// - Same-cycle rf write and read cannot occur (IDLE read vs WB write are exclusive); no hazard logic.
// - Reset values: dec_ready_o=1, all alu_* outputs 0, redirect_o=0, redirect_pc_o=0, busy_o=0,
//   err_o=0, all registers x1..x31 = 0. Reset mid-EXEC/WB aborts with no write.
// CONFIGURATION
// - REG_MANAGER_FWD_EN defined: dec_ready_o also 1 in WB; an instruction accepted in WB whose rs1/rs2
//   equals the WB rd (rd!=0) takes the WB value (forward). Throughput 1 per 2 cycles.
// - Undefined: accept only in IDLE, throughput 1 per 3 cycles, no forwarding mux.
// STRUCTURE
// - cpu_pkg: xlen, unit_e, sub_unit_e, per-sub-unit sel constants, rm_state_e {IDLE,EXEC,WB}.
// - Sub-module reg_file: 32 x XLEN, 2 async read ports, 1 sync write port, x0 hardwired zero.
// TESTING
// - Reset, then read x0..x31 via issued add rd=x1, rs1=xN, imm=0 -> all results 0; dec_ready_o=1.
// - addi x5 = x0 + 0x123 (sub 2, imm) -> rf[5]=0x123 at N+2; dec_ready_o low N+1..N+2.
// - addi x0 = x0 + 7 -> rf[0] stays 0; following add x6 = x0 + x0 -> 0.
// - beq x5,x5 with alu_branch_i=1, alu_result_i=0x80 -> redirect_o one cycle, redirect_pc_o=0x80, no write.
// - Hold alu_ok_i=0 (unit=2'h1) 8 cycles -> err_o=1, dec_ready_o=0 until rst; no rf write.
// - FWD_EN: addi x7=0x10 then back-to-back add x8=x7+x7 accepted in WB -> rf[8]=0x20, 2-cycle spacing.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: execute-unit selects, ALU sub-units and op selects, and issue FSM states.
package cpu_pkg;
  localparam int xlen = 32;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'h0, UNIT_MUL = 2'h1, UNIT_DIV = 2'h2, UNIT_CSR = 2'h3
  } unit_e;

  typedef enum logic [2:0] {
    SU_JUMP = 3'd0, SU_BRANCH = 3'd1, SU_ADD = 3'd2, SU_LOGIC = 3'd3, SU_SHIFT = 3'd4
  } sub_unit_e;

  // op selects within each sub-unit
  localparam logic [5:0] SEL_JAL = 6'd0, SEL_LUI = 6'd1;
  localparam logic [5:0] SEL_BEQ = 6'd0, SEL_BNE = 6'd1, SEL_BLT = 6'd2, SEL_BGE = 6'd3;
  localparam logic [5:0] SEL_ADD = 6'd0, SEL_SUB = 6'd1;
  localparam logic [5:0] SEL_XOR = 6'd0, SEL_OR  = 6'd1, SEL_AND = 6'd2, SEL_SLT = 6'd3;
  localparam logic [5:0] SEL_SLL = 6'd0, SEL_SRL = 6'd1, SEL_SRA = 6'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} rm_state_e;

  typedef struct packed {
    unit_e       unit;
    sub_unit_e   sub_unit;
    logic [5:0]  sel;
    logic [4:0]  rd;
    logic        imm_sel;
  } issue_ctl_t;
endpackage

// File: rtl/reg_file.sv
// 32 x XLEN integer register file: two async read ports, one sync write port, x0 reads zero.
module reg_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/reg_manager.sv
// Issue stage between decoder and ALU: operand read, ALU handshake with timeout, writeback/redirect.
// Optional REG_MANAGER_FWD_EN: accept during WB with forwarding of the WB value.
module reg_manager
  import cpu_pkg::*;
#(
  parameter int XLEN       = xlen,
  parameter int OK_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic [1:0]      dec_unit_i,
  input  logic [2:0]      dec_sub_unit_i,
  input  logic [5:0]      dec_sel_i,
  input  logic [4:0]      dec_rs1_i,
  input  logic [4:0]      dec_rs2_i,
  input  logic [4:0]      dec_rd_i,
  input  logic [XLEN-1:0] dec_imm_i,
  input  logic            dec_imm_sel_i,
  output logic [1:0]      alu_unit_o,
  output logic [2:0]      alu_sub_unit_o,
  output logic [5:0]      alu_sel_o,
  output logic [XLEN-1:0] alu_rs1_o,
  output logic [XLEN-1:0] alu_rs2_o,
  output logic [4:0]      alu_rd_o,
  output logic [XLEN-1:0] alu_immediate_o,
  output logic            alu_imm_o,
  input  logic            alu_ok_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_branch_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o,
  output logic            err_o
);
  localparam int CW = $clog2(OK_TIMEOUT + 1);

  rm_state_e       state, state_nx;
  issue_ctl_t      ctl_q;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, res_q;
  logic [XLEN-1:0] rf_a, rf_b, op_a, op_b;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic            br_q, err_q;
  logic            accept, timeout, wb_we;

  reg_file #(.XLEN(XLEN)) u_rf (
    .clk(clk), .rst(rst),
    .ra1(dec_rs1_i), .ra2(dec_rs2_i), .rd1(rf_a), .rd2(rf_b),
    .we(wb_we), .wa(ctl_q.rd), .wd(res_q)
  );

  assign wb_we = (state == WB) && (ctl_q.sub_unit != SU_BRANCH);

`ifdef REG_MANAGER_FWD_EN
  // an instruction accepted in WB must see the value being written this cycle
  assign dec_ready_o = ((state == IDLE) || (state == WB)) && !err_q;
  assign op_a = (wb_we && ctl_q.rd != 5'd0 && dec_rs1_i == ctl_q.rd) ? res_q : rf_a;
  assign op_b = (wb_we && ctl_q.rd != 5'd0 && dec_rs2_i == ctl_q.rd) ? res_q : rf_b;
`else
  assign dec_ready_o = (state == IDLE) && !err_q;
  assign op_a = rf_a;
  assign op_b = rf_b;
`endif

  assign accept  = dec_valid_i && dec_ready_o;
  assign cnt_nx  = cnt_q + 1'b1;
  assign timeout = (state == EXEC) && !alu_ok_i && (cnt_nx == CW'(OK_TIMEOUT));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (alu_ok_i) state_nx = WB;
               else if (timeout) state_nx = IDLE;
      WB:      state_nx = accept ? EXEC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctl_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ctl_q <= '{unit: unit_e'(dec_unit_i), sub_unit: sub_unit_e'(dec_sub_unit_i),
                   sel: dec_sel_i, rd: dec_rd_i, imm_sel: dec_imm_sel_i};
        rs1_q <= op_a;
        rs2_q <= op_b;
        imm_q <= dec_imm_i;
        cnt_q <= '0;
      end
      if (state == EXEC) begin
        if (alu_ok_i) begin
          res_q <= alu_result_i;
          br_q  <= alu_branch_i;
        end else begin
          cnt_q <= cnt_nx;
        end
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  assign alu_unit_o      = ctl_q.unit;
  assign alu_sub_unit_o  = ctl_q.sub_unit;
  assign alu_sel_o       = ctl_q.sel;
  assign alu_rd_o        = ctl_q.rd;
  assign alu_imm_o       = ctl_q.imm_sel;
  assign alu_rs1_o       = rs1_q;
  assign alu_rs2_o       = rs2_q;
  assign alu_immediate_o = imm_q;
  assign redirect_o      = (state == WB) && (ctl_q.sub_unit == SU_BRANCH) && br_q;
  assign redirect_pc_o   = res_q;
  assign busy_o          = (state != IDLE);
  assign err_o           = err_q;
endmodule

// File: tb/tb_reg_manager.sv
// Bench for reg_manager: acts as decoder and ALU, tracks the register file as a plain array.
module tb_reg_manager;
  localparam int TMO = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        dec_valid = 1'b0, dec_ready;
  logic [1:0]  dec_unit = '0;
  logic [2:0]  dec_sub = '0;
  logic [5:0]  dec_sel = '0;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic [31:0] dec_imm = '0;
  logic        dec_isel = 1'b0;
  logic [1:0]  alu_unit;
  logic [2:0]  alu_sub;
  logic [5:0]  alu_sel;
  logic [31:0] alu_rs1, alu_rs2, alu_immediate, alu_result = '0, redirect_pc;
  logic [4:0]  alu_rd;
  logic        alu_imm, alu_ok = 1'b0, alu_branch = 1'b0, redirect, busy, err;

  reg_manager #(.XLEN(32), .OK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_unit_i(dec_unit),
    .dec_sub_unit_i(dec_sub), .dec_sel_i(dec_sel), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rd_i(dec_rd), .dec_imm_i(dec_imm), .dec_imm_sel_i(dec_isel),
    .alu_unit_o(alu_unit), .alu_sub_unit_o(alu_sub), .alu_sel_o(alu_sel),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2), .alu_rd_o(alu_rd),
    .alu_immediate_o(alu_immediate), .alu_imm_o(alu_imm),
    .alu_ok_i(alu_ok), .alu_result_i(alu_result), .alu_branch_i(alu_branch),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference state: architectural registers plus a pending writeback
  logic [31:0] m [32];
  bit          pend = 0, in_wb = 0;
  logic [4:0]  pend_rd;
  logic [31:0] pend_val;

  // per-cycle expectations consumed by the compare process
  bit          chk_on = 0, e_rst = 1, e_ready = 1, e_busy = 0, e_err = 0, e_redirect = 0, e_exec = 0;
  bit          pin_en = 0;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm, pin_rs1, pin_rs2;
  logic [1:0]  e_unit;
  logic [2:0]  e_sub;
  logic [5:0]  e_sel;
  logic [4:0]  e_rd;
  logic        e_isel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("dec_ready", dec_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("redirect", redirect, e_redirect);
    if (e_rst) begin
      chk("rst_pc", redirect_pc, 0);
      chk("rst_unit", alu_unit, 0);
      chk("rst_sub", alu_sub, 0);
      chk("rst_sel", alu_sel, 0);
      chk("rst_rs1", alu_rs1, 0);
      chk("rst_rs2", alu_rs2, 0);
      chk("rst_rd", alu_rd, 0);
      chk("rst_imm", alu_immediate, 0);
      chk("rst_isel", alu_imm, 0);
    end else begin
      if (e_redirect) chk("redirect_pc", redirect_pc, e_pc);
      if (e_exec) begin
        chk("alu_unit", alu_unit, e_unit);
        chk("alu_sub", alu_sub, e_sub);
        chk("alu_sel", alu_sel, e_sel);
        chk("alu_rs1", alu_rs1, e_rs1);
        chk("alu_rs2", alu_rs2, e_rs2);
        chk("alu_rd", alu_rd, e_rd);
        chk("alu_imm_val", alu_immediate, e_imm);
        chk("alu_imm_sel", alu_imm, e_isel);
      end
      if (pin_en) begin
        chk("pin_rs1", alu_rs1, pin_rs1);
        chk("pin_rs2", alu_rs2, pin_rs2);
      end
    end
  end

  function automatic logic [31:0] alu_ref(input int sub, input int sel, input logic [31:0] a, input logic [31:0] b);
    case (sub)
      0:       return b;
      2:       return sel[0] ? a - b : a + b;
      3:       return a ^ b;
      4:       return a << b[4:0];
      default: return a + b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    if (pend) begin
      if (pend_rd != 5'd0) m[pend_rd] = pend_val;
      pend = 0;
    end
    #1;
  endtask

  task automatic idle_cycle();
    step();
    in_wb = 0;
    e_busy = 0; e_ready = !e_err; e_redirect = 0; e_exec = 0;
  endtask

  task automatic do_reset();
    rst = 1; dec_valid = 0; alu_ok = 0;
    e_rst = 1; e_ready = 1; e_busy = 0; e_err = 0; e_redirect = 0; e_exec = 0; pin_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    pend = 0; in_wb = 0; e_rst = 0;
  endtask

  task automatic issue(input int unit, sub, sel, rs1, rs2, rd, input logic [31:0] imm,
                       input int isel, stall, br, input logic [31:0] tgt,
                       input int pin, input logic [31:0] p1, p2);
    logic [31:0] a, b, res;
`ifndef REG_MANAGER_FWD_EN
    if (in_wb) idle_cycle();
`endif
    dec_unit = 2'(unit); dec_sub = 3'(sub); dec_sel = 6'(sel);
    dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd); dec_imm = imm; dec_isel = 1'(isel);
    dec_valid = 1;
    step();
    dec_valid = 0;
    a = m[rs1]; b = m[rs2];
    e_exec = 1; e_unit = 2'(unit); e_sub = 3'(sub); e_sel = 6'(sel); e_rd = 5'(rd);
    e_rs1 = a; e_rs2 = b; e_imm = imm; e_isel = 1'(isel);
    e_busy = 1; e_ready = 0; e_redirect = 0; in_wb = 0;
    pin_en = (pin != 0); pin_rs1 = p1; pin_rs2 = p2;
    alu_ok = 0;
    if (stall >= TMO) begin
      for (int i = 1; i < TMO; i++) step();
      step();
      e_exec = 0; pin_en = 0; e_err = 1; e_busy = 0; e_ready = 0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      alu_result = $urandom; alu_branch = 1'($urandom);
      step();
    end
    res = (sub == 1) ? tgt : alu_ref(sub, sel, a, (isel != 0) ? imm : b);
    alu_ok = 1; alu_result = res; alu_branch = 1'(br);
    step();
    alu_ok = 0; alu_result = $urandom; alu_branch = 1'($urandom);
    e_exec = 0; pin_en = 0; e_busy = 1;
`ifdef REG_MANAGER_FWD_EN
    e_ready = 1;
`else
    e_ready = 0;
`endif
    e_redirect = (sub == 1) && (br != 0); e_pc = tgt;
    if (sub != 1) begin pend = 1; pend_rd = 5'(rd); pend_val = res; end
    in_wb = 1;
  endtask

  initial begin
    int last_rd;
    for (int i = 0; i < 32; i++) m[i] = '0;
    chk_on = 1;
    do_reset();

    // every register reads zero after reset
    for (int r = 0; r < 32; r++) issue(0, 2, 0, r, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);

    // addi x5 = x0 + 0x123, then read it back
    issue(0, 2, 0, 0, 0, 5, 32'h123, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 2, 0, 5, 0, 1, 0, 1, 1, 0, 0, 1, 32'h123, 0);
    chk("model_x5", m[5], 32'h123);

    // writes to x0 are dropped
    issue(0, 2, 0, 0, 0, 0, 32'd7, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 2, 0, 0, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0);
    issue(0, 2, 0, 6, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0);

    // taken beq x5,x5 -> redirect to 0x80, rd field must not be written
    issue(0, 1, 0, 5, 5, 9, 0, 0, 0, 1, 32'h80, 1, 32'h123, 32'h123);
    chk("beq_redirect", redirect, 1);
    chk("beq_pc", redirect_pc, 32'h80);
    issue(0, 2, 0, 9, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);

    // x7 = 0x10 ; x8 = x7 + x7 back to back ; read x8
    issue(0, 2, 0, 0, 0, 7, 32'h10, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 2, 0, 7, 7, 8, 0, 0, 0, 0, 0, 1, 32'h10, 32'h10);
    issue(0, 2, 0, 8, 0, 3, 0, 1, 0, 0, 0, 1, 32'h20, 0);

    // random traffic; half the time source the previous destination
    last_rd = 1;
    for (int n = 0; n < 120; n++) begin
      int rs1, rd;
      rs1 = ($urandom_range(1) != 0) ? last_rd : $urandom_range(31);
      rd  = $urandom_range(31);
      issue(0, $urandom_range(4), $urandom_range(3), rs1, $urandom_range(31), rd, $urandom,
            $urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom, 0, 0, 0);
      if ($urandom_range(3) == 0) idle_cycle();
      last_rd = rd;
    end

    // ALU never answers: sticky error, no writeback, no further accepts
    issue(1, 2, 0, 5, 0, 11, 32'h55, 1, 99, 0, 0, 0, 0, 0);
    dec_valid = 1;
    repeat (3) step();
    dec_valid = 0;
    chk("err_sticky", err, 1);
    issue_after_err_check: begin end

    do_reset();
    for (int r = 1; r < 32; r++) issue(0, 2, 0, r, r, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_cycle();
    idle_cycle();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
